adder_n_bits_seq: RTL
=====================

ADDER_N_BITS_SEQ -- requirements
Module: adder_n_bits_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (>= 2).
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  request a new operation.
REQ-006 The block SHALL have port A  input  WIDTH  first operand.
REQ-007 The block SHALL have port B  input  WIDTH  second operand.
REQ-008 The block SHALL have port op_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 The block SHALL have port Sum  output  WIDTH  registered result.
REQ-010 The block SHALL have port Cout  output  1  carry out of the MSB.
REQ-011 The block SHALL have ports flagC, flagZ, flagN, flagV  output  1 each  carry, zero, negative, signed overflow.
REQ-012 The block SHALL have port busy  output  1  operation in progress.
REQ-013 The block SHALL have port done  output  1  one-cycle result-valid pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN, DONE; STEPS = WIDTH/CHUNK.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL latch A, B XOR {WIDTH{op_sub}}, carry = op_sub, step counter = 0, and enter RUN.
REQ-016 In RUN, each edge SHALL add one CHUNK-bit slice (LSB slice first) plus the running carry into an internal partial register and advance the counter.
REQ-017 After STEPS RUN edges the block SHALL load Sum, Cout and flags from the completed result and enter DONE; latency start-edge to done-high = STEPS edges.
REQ-018 done SHALL be 1 only in DONE (exactly one cycle); DONE SHALL go to IDLE unless start=1, in which case REQ-015 applies (back-to-back).
REQ-019 busy SHALL be 1 exactly while in RUN.
REQ-020 start while in RUN SHALL be ignored; operands SHALL not be re-sampled.
REQ-021 A, B, op_sub changes after the start edge SHALL not affect the result in flight.
REQ-022 Sum, Cout and flags SHALL change only on the DONE-entry edge; partial results SHALL never appear on outputs, and outputs SHALL hold until the next completion.
REQ-023 Cout and flagC SHALL equal the MSB carry out; for subtraction flagC=1 means no borrow (A >= B unsigned).
REQ-024 flagZ SHALL be 1 iff Sum == 0; flagN SHALL equal Sum[WIDTH-1].
REQ-025 flagV SHALL be 1 iff the latched operand MSBs are equal and differ from Sum[WIDTH-1] (two's complement overflow, using inverted B for subtraction).
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; wrap-around reported only via Cout/flagC/flagV.

Reset
REQ-027 rst_n=0 SHALL immediately, without clock, force state IDLE, Sum=0, Cout=0, flagC=0, flagZ=0, flagN=0, flagV=0, busy=0, done=0, counter and internal registers 0.
REQ-028 Reset asserted in RUN SHALL abort the operation; no done pulse SHALL follow; outputs SHALL read reset values until a later completion.
REQ-029 start SHALL be ignored while rst_n=0; first accepted start is the first edge with rst_n=1 and start=1.

Verification
REQ-030 WIDTH=8, CHUNK=4: A=0x80, B=0xD0, op_sub=0, start one cycle -> busy 2 cycles, done on 2nd edge after start, Sum=0x50, C=1, Z=0, N=0, V=1.
REQ-031 WIDTH=8, CHUNK=4: A=0x7F, B=0x01 add -> Sum=0x80, C=0, N=1, V=1, Z=0; then A=0x05, B=0x05 sub -> Sum=0x00, Z=1, C=1, V=0.
REQ-032 WIDTH=8, CHUNK=4: A=0x0A, B=0x0B sub -> Sum=0xFF, C=0, N=1, V=0, Z=0; start held high through DONE -> second operation launches with no IDLE cycle.
REQ-033 WIDTH=4, CHUNK=1: A=0x2, B=0xD add -> done after 4 edges, Sum=0xF, C=0, N=1, V=0; A=0x8, B=0xD -> Sum=0x5, C=1, V=1.
REQ-034 Start pulse during RUN with different operands, and operand changes mid-RUN -> ignored; result matches first latched operands, single done pulse.
REQ-035 rst_n low for one cycle mid-RUN -> all outputs 0 asynchronously, no done pulse; next start completes normally with correct result.

Source files
------------

// File: rtl/adder_n_bits_seq.sv
// rtl/adder_n_bits_seq.sv - multi-cycle add/subtract, CHUNK bits per clock, with NZCV flags
module adder_n_bits_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op_sub,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             flagC,
  output logic             flagZ,
  output logic             flagN,
  output logic             flagV,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] partial;
  logic             carry;
  logic             msb_a;
  logic             msb_b;
  logic [CW-1:0]    cnt;

  logic [CHUNK:0]       slice_sum;
  logic [WIDTH+CHUNK-1:0] shifted;
  logic [WIDTH-1:0]     result;
  logic                 last;

  // Operands shift right each step; finished slices enter partial from the top,
  // so after STEPS steps the LSB slice has reached bit 0.
  always_comb begin
    slice_sum = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    shifted   = {slice_sum[CHUNK-1:0], partial};
    result    = shifted[WIDTH+CHUNK-1:CHUNK];
    last      = (cnt == CW'(STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      partial <= '0;
      carry   <= 1'b0;
      msb_a   <= 1'b0;
      msb_b   <= 1'b0;
      cnt     <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
      flagC   <= 1'b0;
      flagZ   <= 1'b0;
      flagN   <= 1'b0;
      flagV   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= A;
            b_r     <= B ^ {WIDTH{op_sub}};
            carry   <= op_sub;
            msb_a   <= A[WIDTH-1];
            msb_b   <= B[WIDTH-1] ^ op_sub;
            cnt     <= '0;
            partial <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          carry   <= slice_sum[CHUNK];
          partial <= result;
          cnt     <= cnt + 1'b1;
          if (last) begin
            Sum   <= result;
            Cout  <= slice_sum[CHUNK];
            flagC <= slice_sum[CHUNK];
            flagZ <= (result == '0);
            flagN <= result[WIDTH-1];
            flagV <= (msb_a == msb_b) && (result[WIDTH-1] != msb_a);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
